// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic        we;
    reg_idx_t    rd;
    logic [31:0] data;
  } wb_req_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: NREQ valid/ready lanes carrying a dest index and write data each.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_W     = 5
);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*ADDR_W-1:0]     req_rd;
  logic [NREQ*DATA_WIDTH-1:0] req_data;

  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, ascending, wrapping.
module rr_pick
  import regfile_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned   k;
  logic [IW-1:0] kw;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    kw    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      k  = (32'(ptr_i) + off) % N;
      kw = IW'(k);
      if (!any_o && req_i[kw]) begin
        gnt_o[kw] = 1'b1;
        idx_o     = kw;
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ writeback sources onto the single regfile write port and flags read hazards.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (lowest index wins).
module regfile_wb_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_W     = regfile_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  regfile_wb_arbiter_if.slave    req_if,
  input  logic [ADDR_W-1:0]      rs1,
  input  logic [ADDR_W-1:0]      rs2,
  output logic                   WE3,
  output logic [ADDR_W-1:0]      A3,
  output logic [DATA_WIDTH-1:0]  WD3,
  output logic                   haz1,
  output logic                   haz2
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]       gnt;
  logic [IW-1:0]         win;
  logic [IW-1:0]         ptr_q;
  logic                  any;
  logic                  accept;
  logic [ADDR_W-1:0]     rd_sel;
  logic [DATA_WIDTH-1:0] data_sel;

  logic                  we3_q, we3_d;
  logic [ADDR_W-1:0]     a3_q, a3_d;
  logic [DATA_WIDTH-1:0] wd3_q, wd3_d;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req_i (req_if.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any)
  );

  // Flush suppresses the grant outright so no requester believes it was accepted.
  assign accept           = any && !flush;
  assign req_if.req_ready = flush ? '0 : gnt;
  assign rd_sel           = req_if.req_rd[win*ADDR_W +: ADDR_W];
  assign data_sel         = req_if.req_data[win*DATA_WIDTH +: DATA_WIDTH];

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign ptr_q = '0;
`endif

  // Writes to x0 still consume the grant but never reach the regfile.
  always_comb begin
    we3_d = accept && (rd_sel != '0);
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (accept) begin
      a3_d  = rd_sel;
      wd3_d = data_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
    end
  end

  assign WE3  = we3_q;
  assign A3   = a3_q;
  assign WD3  = wd3_q;
  assign haz1 = we3_q && (a3_q == rs1) && (rs1 != '0);
  assign haz2 = we3_q && (a3_q == rs2) && (rs2 != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic vs a queue-free reference model.
module tb_regfile_wb_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] rs1   = '0;
  logic [AW-1:0] rs2   = '0;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic          haz1, haz2;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: expected in-flight write and arbitration pointer.
  int            m_ptr = 0;
  logic          m_we  = 1'b0;
  logic [AW-1:0] m_a3  = '0;
  logic [DW-1:0] m_wd  = '0;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(
    .NREQ       (NREQ),
    .DATA_WIDTH (DW),
    .ADDR_W     (AW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .req_if (bus),
    .rs1    (rs1),
    .rs2    (rs2),
    .WE3    (WE3),
    .A3     (A3),
    .WD3    (WD3),
    .haz1   (haz1),
    .haz2   (haz2)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [NREQ-1:0] v);
    int p;
    int k;
`ifdef WB_ARB_ROUND_ROBIN_EN
    p = m_ptr;
`else
    p = 0;
`endif
    for (int o = 0; o < NREQ; o++) begin
      k = (p + o) % NREQ;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_edge(input int w);
    m_we = 1'b0;
    if (w >= 0) begin
      m_a3 = bus.req_rd[w*AW +: AW];
      m_wd = bus.req_data[w*DW +: DW];
      m_we = (m_a3 != '0);
      m_ptr = (w + 1) % NREQ;
    end
    if (flush) m_ptr = 0;
  endtask

  // Called at a falling edge with inputs set; returns observed and modelled grant, then steps past the rising edge.
  task automatic clk_cycle(output logic [NREQ-1:0] obs, output logic [NREQ-1:0] exp, output int w);
    #1;
    obs = bus.req_ready;
    w   = flush ? -1 : pick(bus.req_valid);
    exp = '0;
    if (w >= 0) exp[w] = 1'b1;
    model_edge(w);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.req_valid[i]           = 1'b1;
    bus.req_rd[i*AW +: AW]     = rd;
    bus.req_data[i*DW +: DW]   = d;
  endtask

  task automatic test_reset();
    logic [NREQ-1:0] o, e;
    int w;
    #1;
    tests++;
    if (WE3 !== 1'b0 || A3 !== '0 || WD3 !== '0) begin
      fails++;
      $display("FAIL reset_init: WE3=%0b A3=%0d WD3=%h, want 0/0/0", WE3, A3, WD3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 5'd9, 32'hA5A5_0009);
    clk_cycle(o, e, w);
    tests++;
    if (o !== 2'b01) begin
      fails++;
      $display("FAIL reset_pre_grant: ready=%b, want 01", o);
    end
    tests++;
    if (WE3 !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'hA5A5_0009) begin
      fails++;
      $display("FAIL reset_pre_write: WE3=%0b A3=%0d WD3=%h, want 1/9/a5a50009", WE3, A3, WD3);
    end
    bus.req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (WE3 !== 1'b0 || A3 !== '0 || WD3 !== '0) begin
      fails++;
      $display("FAIL reset_async: WE3=%0b A3=%0d WD3=%h, want 0/0/0", WE3, A3, WD3);
    end
    m_ptr = 0; m_we = 1'b0; m_a3 = '0; m_wd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 5'd1, 32'h1);
    set_req(1, 5'd2, 32'h2);
    #1;
    tests++;
    if (bus.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL reset_first_grant: ready=%b, want 01", bus.req_ready);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] o, e;
    int w;
    @(negedge clk);
    set_req(1, 5'd5, 32'hDEADBEEF);
    clk_cycle(o, e, w);
    tests++;
    if (o !== 2'b10) begin
      fails++;
      $display("FAIL single_ready: ready=%b, want 10", o);
    end
    tests++;
    if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_write: WE3=%0b A3=%0d WD3=%h, want 1/5/deadbeef", WE3, A3, WD3);
    end
    bus.req_valid = '0;
    @(negedge clk);
    clk_cycle(o, e, w);
    tests++;
    if (WE3 !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: WE3=%0b, want 0", WE3);
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] o, e, want;
    logic [DW-1:0]   d [NREQ];
    int w;
    @(negedge clk);
    d[0] = $urandom; d[1] = $urandom;
    set_req(0, 5'd3, d[0]);
    set_req(1, 5'd4, d[1]);
    for (int c = 0; c < 4; c++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
      want = 2'b01;
`endif
      clk_cycle(o, e, w);
      tests++;
      if (o !== want) begin
        fails++;
        $display("FAIL contention_grant[%0d]: ready=%b, want %b", c, o, want);
      end
      tests++;
      if (WE3 !== 1'b1 || A3 !== (want[0] ? 5'd3 : 5'd4) || WD3 !== (want[0] ? d[0] : d[1])) begin
        fails++;
        $display("FAIL contention_write[%0d]: WE3=%0b A3=%0d WD3=%h", c, WE3, A3, WD3);
      end
      @(negedge clk);
      if (want[0]) begin d[0] = $urandom; set_req(0, 5'd3, d[0]); end
      else         begin d[1] = $urandom; set_req(1, 5'd4, d[1]); end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_x0();
    logic [NREQ-1:0] o, e;
    int w;
    @(negedge clk);
    set_req(0, 5'd0, 32'h1234);
    rs1 = 5'd10;
    clk_cycle(o, e, w);
    bus.req_valid = '0;
    tests++;
    if (o !== 2'b01) begin
      fails++;
      $display("FAIL x0_ready: ready=%b, want 01", o);
    end
    tests++;
    if (WE3 !== 1'b0 || haz1 !== 1'b0) begin
      fails++;
      $display("FAIL x0_write: WE3=%0b haz1=%0b, want 0/0", WE3, haz1);
    end
    rs1 = '0;
  endtask

  task automatic test_hazard();
    logic [NREQ-1:0] o, e;
    int w;
    @(negedge clk);
    set_req(0, 5'd10, 32'hCAFE_000A);
    clk_cycle(o, e, w);
    bus.req_valid = '0;
    @(negedge clk);
    rs1 = 5'd10;
    rs2 = 5'd0;
    #1;
    tests++;
    if (haz1 !== 1'b1 || haz2 !== 1'b0) begin
      fails++;
      $display("FAIL hazard_hit: haz1=%0b haz2=%0b, want 1/0", haz1, haz2);
    end
    clk_cycle(o, e, w);
    tests++;
    if (haz1 !== 1'b0) begin
      fails++;
      $display("FAIL hazard_clear: haz1=%0b, want 0", haz1);
    end
    rs1 = '0;
  endtask

  task automatic test_flush();
    logic [NREQ-1:0] o, e;
    int w;
    @(negedge clk);
    set_req(0, 5'd7, 32'h7777_0000);
    set_req(1, 5'd7, 32'h7777_0001);
    flush = 1'b1;
    clk_cycle(o, e, w);
    tests++;
    if (o !== 2'b00) begin
      fails++;
      $display("FAIL flush_ready: ready=%b, want 00", o);
    end
    tests++;
    if (WE3 !== 1'b0) begin
      fails++;
      $display("FAIL flush_we: WE3=%0b, want 0", WE3);
    end
    @(negedge clk);
    flush = 1'b0;
    clk_cycle(o, e, w);
    tests++;
    if (o !== 2'b01) begin
      fails++;
      $display("FAIL flush_next_grant: ready=%b, want 01", o);
    end
    tests++;
    if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'h7777_0000) begin
      fails++;
      $display("FAIL flush_next_write: WE3=%0b A3=%0d WD3=%h", WE3, A3, WD3);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] o, e;
    int w;
    int waits [NREQ];
    logic exp_h1, exp_h2;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(3) != 0)
          set_req(i, ($urandom_range(7) == 0) ? AW'(0) : AW'($urandom), $urandom);
      end
      flush = ($urandom_range(15) == 0);
      rs1 = $urandom_range(1) ? m_a3 : AW'($urandom);
      rs2 = $urandom_range(1) ? m_a3 : AW'($urandom);
      clk_cycle(o, e, w);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL rand_ready[%0d]: ready=%b, want %b", c, o, e);
      end
      tests++;
      if (WE3 !== m_we) begin
        fails++;
        $display("FAIL rand_we[%0d]: WE3=%0b, want %0b", c, WE3, m_we);
      end
      if (m_we) begin
        tests++;
        if (A3 !== m_a3 || WD3 !== m_wd) begin
          fails++;
          $display("FAIL rand_write[%0d]: A3=%0d WD3=%h, want %0d/%h", c, A3, WD3, m_a3, m_wd);
        end
      end
      exp_h1 = m_we && (m_a3 == rs1) && (rs1 != '0);
      exp_h2 = m_we && (m_a3 == rs2) && (rs2 != '0);
      tests++;
      if (haz1 !== exp_h1 || haz2 !== exp_h2) begin
        fails++;
        $display("FAIL rand_haz[%0d]: haz1=%0b haz2=%0b, want %0b/%0b", c, haz1, haz2, exp_h1, exp_h2);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (flush || i == w || !bus.req_valid[i]) waits[i] = 0;
        else waits[i]++;
      end
`ifdef WB_ARB_ROUND_ROBIN_EN
      tests++;
      if (waits[0] >= NREQ || waits[1] >= NREQ) begin
        fails++;
        $display("FAIL rand_starve[%0d]: waits=%0d/%0d, want < %0d", c, waits[0], waits[1], NREQ);
      end
`endif
      if (w >= 0) bus.req_valid[w] = 1'b0;
    end
    flush = 1'b0;
    bus.req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_hazard();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
